// File: rtl/pwm_compare_dt.sv
// pwm_compare_dt: multi-channel carrier comparator with complementary gate outputs and
// programmable dead-time.
//
// A shared carrier is compared against a per-channel shadowed compare value. The shadow
// (cmp_active) is reloaded from compare_in on a selectable carrier event so a duty change
// never lands mid-period. Each channel then runs a small IDLE/HIGH/LOW/DEAD state machine
// that inserts `deadtime` cycles with both gates off between every high/low change.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   carrier       shared carrier count
//   evt_zero      one-cycle pulse, carrier at minimum
//   evt_peak      one-cycle pulse, carrier at maximum
//   compare_in    new compare values, channel k at [k*PWMCOUNT_WIDTH +: PWMCOUNT_WIDTH]
//   upd_lock      high inhibits the shadow load
//   pwm_onoff     per-channel enable
//   deadtime      dead interval in clk cycles, shared by all channels
//   cmp_active    compare values currently in use
//   upd_ack       one-cycle pulse the cycle after a shadow load
//   pwm_h, pwm_l  high-side / low-side gates, never both 1
module pwm_compare_dt #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned PWMCOUNT_WIDTH = 16,
    parameter int unsigned DT_WIDTH       = 10,
    // 0: load on evt_zero, 1: on evt_peak, 2: on either, 3: every cycle
    parameter int unsigned UPD_MODE       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PWMCOUNT_WIDTH-1:0]        carrier,
    input  logic                             evt_zero,
    input  logic                             evt_peak,
    input  logic [N_CH*PWMCOUNT_WIDTH-1:0]   compare_in,
    input  logic                             upd_lock,
    input  logic [N_CH-1:0]                  pwm_onoff,
    input  logic [DT_WIDTH-1:0]              deadtime,
    output logic [N_CH*PWMCOUNT_WIDTH-1:0]   cmp_active,
    output logic                             upd_ack,
    output logic [N_CH-1:0]                  pwm_h,
    output logic [N_CH-1:0]                  pwm_l
);

    localparam int unsigned W = PWMCOUNT_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDead
    } state_e;

    // ------------------------------------------------------------------
    // Shadow load
    // ------------------------------------------------------------------
    logic                load_evt;
    logic                do_load;
    logic [N_CH*W-1:0]   cmp_active_q;
    logic                upd_ack_q;

    always_comb begin
        load_evt = 1'b0;
        case (UPD_MODE)
            0:       load_evt = evt_zero;
            1:       load_evt = evt_peak;
            2:       load_evt = evt_zero | evt_peak;  // coincident events still load once
            3:       load_evt = 1'b1;
            default: load_evt = 1'b0;
        endcase
    end

    assign do_load = load_evt & ~upd_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_active_q <= '0;
            upd_ack_q    <= 1'b0;
        end else begin
            upd_ack_q <= do_load;
            if (do_load) begin
                cmp_active_q <= compare_in;
            end
        end
    end

    assign cmp_active = cmp_active_q;
    assign upd_ack    = upd_ack_q;

    // ------------------------------------------------------------------
    // Registered compare: high while carrier is below the compare value
    // ------------------------------------------------------------------
    logic [N_CH-1:0] raw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                raw_q[k] <= (carrier < cmp_active_q[k*W +: W]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel dead-time state machines
    // ------------------------------------------------------------------
    logic dt_zero;
    assign dt_zero = (deadtime == '0);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_e              state_q;
        logic [DT_WIDTH-1:0] dt_cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= StIdle;
                dt_cnt_q <= '0;
            end else if (!pwm_onoff[k]) begin
                // Disable wins over every other transition, including a running dead count.
                state_q  <= StIdle;
                dt_cnt_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (dt_zero) begin
                            state_q <= raw_q[k] ? StHigh : StLow;
                        end else begin
                            state_q  <= StDead;
                            dt_cnt_q <= deadtime;
                        end
                    end
                    StHigh: begin
                        if (!raw_q[k]) begin
                            if (dt_zero) begin
                                state_q <= StLow;
                            end else begin
                                state_q  <= StDead;
                                dt_cnt_q <= deadtime;
                            end
                        end
                    end
                    StLow: begin
                        if (raw_q[k]) begin
                            if (dt_zero) begin
                                state_q <= StHigh;
                            end else begin
                                state_q  <= StDead;
                                dt_cnt_q <= deadtime;
                            end
                        end
                    end
                    StDead: begin
                        // Raw toggles inside the window are ignored; the exit side is
                        // whatever raw says in the final cycle, so short pulses vanish.
                        if (dt_cnt_q <= DT_WIDTH'(1)) begin
                            state_q  <= raw_q[k] ? StHigh : StLow;
                            dt_cnt_q <= '0;
                        end else begin
                            dt_cnt_q <= dt_cnt_q - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        dt_cnt_q <= '0;
                    end
                endcase
            end
        end

        // Gates decode straight from the state register, so they can never overlap.
        assign pwm_h[k] = (state_q == StHigh);
        assign pwm_l[k] = (state_q == StLow);
    end

endmodule

// File: tb/tb_pwm_compare_dt.sv
// Scoreboard bench for pwm_compare_dt: stimulus pushes expected values tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_pwm_compare_dt;

    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int DTW  = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        carrier;
    logic                evt_zero;
    logic                evt_peak;
    logic [N_CH*W-1:0]   compare_in;
    logic                upd_lock;
    logic [N_CH-1:0]     pwm_onoff;
    logic [DTW-1:0]      deadtime;
    logic [N_CH*W-1:0]   cmp_active;
    logic [N_CH*W-1:0]   cmp_active2;
    logic                upd_ack;
    logic                upd_ack2;
    logic [N_CH-1:0]     pwm_h;
    logic [N_CH-1:0]     pwm_l;
    logic [N_CH-1:0]     pwm_h2;
    logic [N_CH-1:0]     pwm_l2;

    always #5 clk = ~clk;

    pwm_compare_dt #(
        .N_CH(N_CH), .PWMCOUNT_WIDTH(W), .DT_WIDTH(DTW), .UPD_MODE(0)
    ) u_dut (
        .clk(clk), .rst(rst), .carrier(carrier), .evt_zero(evt_zero), .evt_peak(evt_peak),
        .compare_in(compare_in), .upd_lock(upd_lock), .pwm_onoff(pwm_onoff),
        .deadtime(deadtime), .cmp_active(cmp_active), .upd_ack(upd_ack),
        .pwm_h(pwm_h), .pwm_l(pwm_l)
    );

    // Second instance in "either event" mode, sharing all inputs.
    pwm_compare_dt #(
        .N_CH(N_CH), .PWMCOUNT_WIDTH(W), .DT_WIDTH(DTW), .UPD_MODE(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .carrier(carrier), .evt_zero(evt_zero), .evt_peak(evt_peak),
        .compare_in(compare_in), .upd_lock(upd_lock), .pwm_onoff(pwm_onoff),
        .deadtime(deadtime), .cmp_active(cmp_active2), .upd_ack(upd_ack2),
        .pwm_h(pwm_h2), .pwm_l(pwm_l2)
    );

    typedef enum int {KH, KL, KHV, KLV, KACK, KCMP, KACK2, KCMP2} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        int          ch;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] actual(kind_e k, int ch);
        case (k)
            KH:      return {31'b0, pwm_h[ch]};
            KL:      return {31'b0, pwm_l[ch]};
            KHV:     return {28'b0, pwm_h};
            KLV:     return {28'b0, pwm_l};
            KACK:    return {31'b0, upd_ack};
            KCMP:    return {16'b0, cmp_active[ch*W +: W]};
            KACK2:   return {31'b0, upd_ack2};
            KCMP2:   return {16'b0, cmp_active2[ch*W +: W]};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        checks++;
        if ((pwm_h & pwm_l) != 0 || (pwm_h2 & pwm_l2) != 0) begin
            failures++;
            $display("FAIL no_overlap cyc=%0d got h=%b l=%b h2=%b l2=%b required no common bit",
                     cyc, pwm_h, pwm_l, pwm_h2, pwm_l2);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act = actual(sb[i].kind, sb[i].ch);
                checks++;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d ch=%0d got=%0h required=%0h (due cyc %0d)",
                             sb[i].name, cyc, sb[i].ch, act, sb[i].val, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(int lat, kind_e k, int ch, logic [31:0] v, string nm);
        exp_t e;
        e.cyc  = cyc + lat;
        e.kind = k;
        e.ch   = ch;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_hl(int lat, int ch, bit h, bit l, string nm);
        push(lat, KH, ch, {31'b0, h}, nm);
        push(lat, KL, ch, {31'b0, l}, nm);
    endtask

    // Edge through a dead window of 5: old side at +1, dead +2..+6, new side +7..+last.
    task automatic exp_dead5(int ch, bit oh, bit ol, bit nh, bit nl, int last, string nm);
        exp_hl(1, ch, oh, ol, nm);
        for (int d = 2; d <= 6; d++) exp_hl(d, ch, 1'b0, 1'b0, nm);
        for (int d = 7; d <= last; d++) exp_hl(d, ch, nh, nl, nm);
    endtask

    logic [N_CH*W-1:0] c1;
    logic [N_CH*W-1:0] c2;
    logic [N_CH*W-1:0] c3;
    logic [W-1:0]      gvals [7];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no end of run required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        c1 = {16'd0, 16'd100, 16'd10, 16'd100};
        c2 = {16'd0, 16'd100, 16'd10, 16'd50};
        c3 = {16'd0, 16'd100, 16'd20, 16'd100};
        gvals = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0001};

        rst = 1'b1; carrier = '0; evt_zero = 1'b0; evt_peak = 1'b0; compare_in = '0;
        upd_lock = 1'b0; pwm_onoff = '0; deadtime = '0;

        // Reset
        tick(); tick(); tick();
        rst = 1'b0;
        push(0, KHV, 0, 0, "rst_pwm_h");
        push(0, KLV, 0, 0, "rst_pwm_l");
        push(0, KACK, 0, 0, "rst_ack");
        for (int k = 0; k < N_CH; k++) push(0, KCMP, k, 0, "rst_cmp");
        tick();
        push(0, KHV, 0, 0, "idle_pwm_h");
        push(0, KLV, 0, 0, "idle_pwm_l");

        // Initial load on evt_zero
        compare_in = c1;
        evt_zero = 1'b1;
        push(1, KACK, 0, 1, "load_ack");
        push(2, KACK, 0, 0, "load_ack_once");
        push(1, KACK2, 0, 1, "load_ack2");
        push(1, KCMP, 0, 100, "load_cmp0");
        push(1, KCMP, 1, 10, "load_cmp1");
        push(1, KCMP, 2, 100, "load_cmp2");
        push(1, KCMP, 3, 0, "load_cmp3");
        push(1, KCMP2, 1, 10, "load2_cmp1");
        tick();
        evt_zero = 1'b0;
        tick(); tick();

        // Ch0 basic compare and ch3 compare=0, deadtime 0
        pwm_onoff = 4'b1001;
        for (int v = 0; v < 200; v++) begin
            carrier = W'(v);
            exp_hl(2, 0, v < 100, v >= 100, "ramp_ch0");
            exp_hl(2, 3, 1'b0, 1'b1, "cmp0_ch3");
            if (v == 150) begin
                compare_in = c2;
                push(1, KCMP, 0, 100, "shadow_hold");
                push(2, KCMP, 0, 100, "shadow_hold");
            end
            tick();
        end

        // Shadow load of the mid-period change at evt_zero
        carrier = '0;
        evt_zero = 1'b1;
        push(1, KACK, 0, 1, "upd_ack");
        push(2, KACK, 0, 0, "upd_ack_once");
        push(1, KCMP, 0, 50, "shadow_load");
        tick();
        evt_zero = 1'b0;
        for (int v = 1; v < 80; v++) begin
            carrier = W'(v);
            exp_hl(2, 0, v < 50, v >= 50, "ramp50_ch0");
            tick();
        end

        // Locked event: nothing loads
        carrier = '0;
        evt_zero = 1'b1;
        upd_lock = 1'b1;
        compare_in = c3;
        push(1, KACK, 0, 0, "lock_ack");
        push(1, KCMP, 0, 50, "lock_cmp");
        push(2, KCMP, 0, 50, "lock_cmp");
        push(1, KACK2, 0, 0, "lock_ack2");
        push(1, KCMP2, 1, 10, "lock_cmp2");
        tick();
        evt_zero = 1'b0;
        upd_lock = 1'b0;
        tick();

        // evt_peak alone: only the mode-2 instance loads
        evt_peak = 1'b1;
        push(1, KACK, 0, 0, "peak_ack_m0");
        push(1, KCMP, 1, 10, "peak_cmp_m0");
        push(1, KACK2, 0, 1, "peak_ack_m2");
        push(1, KCMP2, 1, 20, "peak_cmp_m2");
        tick();
        evt_peak = 1'b0;
        tick();

        // Both events together: single load in mode 2
        compare_in = c1;
        evt_zero = 1'b1;
        evt_peak = 1'b1;
        push(1, KACK, 0, 1, "both_ack_m0");
        push(1, KCMP, 0, 100, "both_cmp_m0");
        push(1, KACK2, 0, 1, "both_ack_m2");
        push(2, KACK2, 0, 0, "both_ack_m2_once");
        push(1, KCMP2, 1, 10, "both_cmp_m2");
        tick();
        evt_zero = 1'b0;
        evt_peak = 1'b0;

        // Disable ch3 from LOW
        pwm_onoff[3] = 1'b0;
        exp_hl(0, 3, 1'b0, 1'b1, "ch3_before_off");
        exp_hl(1, 3, 1'b0, 1'b0, "ch3_off");
        tick();

        // Dead-time 5, settle ch0/ch1 low
        deadtime = 10'd5;
        carrier = 16'd150;
        pwm_onoff = 4'b0011;
        repeat (14) tick();
        exp_hl(0, 0, 1'b0, 1'b1, "dt_settle_ch0");
        exp_hl(0, 1, 1'b0, 1'b1, "dt_settle_ch1");

        // 3-cycle pulse shorter than dead-time: absorbed on both channels
        exp_dead5(0, 1'b0, 1'b1, 1'b0, 1'b1, 12, "pulse_ch0");
        exp_dead5(1, 1'b0, 1'b1, 1'b0, 1'b1, 12, "pulse_ch1");
        carrier = 16'd5;
        tick(); tick(); tick();
        carrier = 16'd150;
        repeat (10) tick();

        // Rising edge through dead-time
        carrier = '0;
        exp_dead5(0, 1'b0, 1'b1, 1'b1, 1'b0, 11, "rise_ch0");
        exp_dead5(1, 1'b0, 1'b1, 1'b1, 1'b0, 11, "rise_ch1");
        repeat (12) tick();

        // Falling edge through dead-time
        carrier = 16'd150;
        exp_dead5(0, 1'b1, 1'b0, 1'b0, 1'b1, 11, "fall_ch0");
        repeat (12) tick();

        // Ch2 disabled while in DEAD, then re-enabled with deadtime 4
        pwm_onoff[2] = 1'b1;
        for (int d = 1; d <= 10; d++) exp_hl(d, 2, 1'b0, 1'b0, "ch2_off_in_dead");
        tick(); tick();
        pwm_onoff[2] = 1'b0;
        tick(); tick(); tick();
        carrier = '0;
        repeat (5) tick();
        deadtime = 10'd4;
        pwm_onoff[2] = 1'b1;
        for (int d = 1; d <= 4; d++) exp_hl(d, 2, 1'b0, 1'b0, "reenable_dead");
        for (int d = 5; d <= 7; d++) exp_hl(d, 2, 1'b1, 1'b0, "reenable_high");
        tick(); tick();
        deadtime = 10'd9;  // must not stretch the window already running
        repeat (8) tick();

        // Reset while channels are in DEAD
        carrier = 16'd150;
        repeat (4) tick();
        rst = 1'b1;
        push(1, KHV, 0, 0, "rst_dead_h");
        push(1, KLV, 0, 0, "rst_dead_l");
        push(1, KACK, 0, 0, "rst_dead_ack");
        for (int k = 0; k < N_CH; k++) push(1, KCMP, k, 0, "rst_dead_cmp");
        tick();
        rst = 1'b0;
        push(1, KHV, 0, 0, "after_rst_h");
        push(1, KLV, 0, 0, "after_rst_l");
        repeat (14) tick();

        // Compare 0xFFFF: high for every carrier except 0xFFFF
        deadtime = '0;
        pwm_onoff = 4'b0010;
        carrier = '0;
        compare_in = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        evt_zero = 1'b1;
        push(1, KCMP, 1, 32'h0000_FFFF, "max_cmp_load");
        tick();
        evt_zero = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            carrier = gvals[i];
            exp_hl(2, 1, gvals[i] != 16'hFFFF, gvals[i] == 16'hFFFF, "max_cmp_ch1");
            tick();
        end
        repeat (4) tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
